// File: rtl/ysyx_25010008_exec_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with bus watchdog, halt and write-enable gating.
// Performance counters are built only when YSYX_25010008_PERF_EN is defined.
module ysyx_25010008_exec_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        ifu_req,
  input  logic        ifu_ack,
  output logic        inst_wen,
  input  logic        dec_r_wen,
  input  logic        dec_csr_wen1,
  input  logic        dec_csr_wen2,
  input  logic        dec_mem_ren,
  input  logic        dec_mem_wen,
  input  logic        dec_halt,
  output logic        lsu_req,
  input  logic        lsu_ack,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic        csr_wen1,
  output logic        csr_wen2,
  output logic        retire,
  output logic        halted,
  output logic        bus_err
`ifdef YSYX_25010008_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_retire,
  output logic [31:0] perf_mem_stall
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam bit          WDOG_EN   = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic        bus_err_q, bus_err_d;
  logic        wdog_hit_s;

  logic ifu_req_s, inst_wen_s, lsu_req_s, pc_wen_s, rf_wen_s;
  logic csr_wen1_s, csr_wen2_s, retire_s, halted_s;

  assign wdog_hit_s = WDOG_EN && (wdog_q == TIMEOUT_W);

  // Next-state, watchdog and decoded (ungated) outputs.
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    bus_err_d  = bus_err_q;
    ifu_req_s  = 1'b0;
    inst_wen_s = 1'b0;
    lsu_req_s  = 1'b0;
    pc_wen_s   = 1'b0;
    rf_wen_s   = 1'b0;
    csr_wen1_s = 1'b0;
    csr_wen2_s = 1'b0;
    retire_s   = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wdog_d  = 16'd0;
      end
      ST_FETCH: begin
        ifu_req_s = 1'b1;
        if (ifu_ack) begin
          inst_wen_s = 1'b1;
          state_d    = ST_EXEC;
        end else if (wdog_hit_s) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_EXEC: begin
        if (dec_halt) begin
          state_d = ST_HALT;
        end else if (dec_mem_ren || dec_mem_wen) begin
          state_d = ST_MEM;
          wdog_d  = 16'd0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req_s = 1'b1;
        if (lsu_ack) begin
          state_d = ST_WB;
        end else if (wdog_hit_s) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_WB: begin
        pc_wen_s   = 1'b1;
        retire_s   = 1'b1;
        rf_wen_s   = dec_r_wen;
        csr_wen1_s = dec_csr_wen1;
        csr_wen2_s = dec_csr_wen2;
        state_d    = ST_FETCH;
        wdog_d     = 16'd0;
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, watchdog counter and sticky bus error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wdog_q    <= 16'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs are forced low while reset is held so an abandoned WB never writes.
  assign ifu_req  = reset_n & ifu_req_s;
  assign inst_wen = reset_n & inst_wen_s;
  assign lsu_req  = reset_n & lsu_req_s;
  assign pc_wen   = reset_n & pc_wen_s;
  assign rf_wen   = reset_n & rf_wen_s;
  assign csr_wen1 = reset_n & csr_wen1_s;
  assign csr_wen2 = reset_n & csr_wen2_s;
  assign retire   = reset_n & retire_s;
  assign halted   = reset_n & halted_s;
  assign bus_err  = reset_n & bus_err_q;

`ifdef YSYX_25010008_PERF_EN
  logic [63:0] perf_cycle_q, perf_cycle_d;
  logic [63:0] perf_retire_q, perf_retire_d;
  logic [31:0] perf_mem_stall_q, perf_mem_stall_d;

  // Counter increments; all three stop once the core sits in HALT.
  always_comb begin
    perf_cycle_d     = perf_cycle_q;
    perf_retire_d    = perf_retire_q;
    perf_mem_stall_d = perf_mem_stall_q;
    if (state_q != ST_IDLE && state_q != ST_HALT) begin
      perf_cycle_d = perf_cycle_q + 64'd1;
    end else begin
      perf_cycle_d = perf_cycle_q;
    end
    if (retire_s) begin
      perf_retire_d = perf_retire_q + 64'd1;
    end else begin
      perf_retire_d = perf_retire_q;
    end
    if (state_q == ST_MEM && !lsu_ack) begin
      perf_mem_stall_d = perf_mem_stall_q + 32'd1;
    end else begin
      perf_mem_stall_d = perf_mem_stall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_cycle_q     <= 64'd0;
      perf_retire_q    <= 64'd0;
      perf_mem_stall_q <= 32'd0;
    end else begin
      perf_cycle_q     <= perf_cycle_d;
      perf_retire_q    <= perf_retire_d;
      perf_mem_stall_q <= perf_mem_stall_d;
    end
  end

  assign perf_cycle     = perf_cycle_q;
  assign perf_retire    = perf_retire_q;
  assign perf_mem_stall = perf_mem_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25010008_exec_ctrl.sv
// Scoreboard bench for ysyx_25010008_exec_ctrl: per-instruction expectations are queued at issue
// and popped when the controller retires or halts.
module tb_ysyx_25010008_exec_ctrl;
  localparam int unsigned TO = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ifu_req, ifu_ack, inst_wen;
  logic dec_r_wen, dec_csr_wen1, dec_csr_wen2, dec_mem_ren, dec_mem_wen, dec_halt;
  logic lsu_req, lsu_ack, pc_wen, rf_wen, csr_wen1, csr_wen2, retire, halted, bus_err;
`ifdef YSYX_25010008_PERF_EN
  logic [63:0] perf_cycle, perf_retire;
  logic [31:0] perf_mem_stall;
`endif
  logic [9:0] outs;

  typedef struct {
    bit   is_halt;
    logic rf;
    logic c1;
    logic c2;
    int   lat;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign outs = {ifu_req, inst_wen, lsu_req, pc_wen, rf_wen, csr_wen1, csr_wen2, retire, halted, bus_err};

  ysyx_25010008_exec_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_req(ifu_req), .ifu_ack(ifu_ack), .inst_wen(inst_wen),
    .dec_r_wen(dec_r_wen), .dec_csr_wen1(dec_csr_wen1), .dec_csr_wen2(dec_csr_wen2),
    .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen), .dec_halt(dec_halt),
    .lsu_req(lsu_req), .lsu_ack(lsu_ack),
    .pc_wen(pc_wen), .rf_wen(rf_wen), .csr_wen1(csr_wen1), .csr_wen2(csr_wen2),
    .retire(retire), .halted(halted), .bus_err(bus_err)
`ifdef YSYX_25010008_PERF_EN
    , .perf_cycle(perf_cycle), .perf_retire(perf_retire), .perf_mem_stall(perf_mem_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold reset for n cycles, then release; returns inside the IDLE cycle.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset_n = 1'b0;
    ifu_ack = 1'b0;
    lsu_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1 chk("outs_in_reset", outs, 10'd0);
      @(negedge clock);
    end
    reset_n = 1'b1;
    #1 chk("outs_idle", outs, 10'd0);
  endtask

  // Issue one instruction; acks arrive after iw / lw request wait cycles.
  task automatic run_instr(input logic r, input logic c1, input logic c2, input logic mr,
                           input logic mw, input logic hlt, input int iw, input int lw);
    exp_t e;
    int cyc, if_seen, ls_seen;
    bit done;
    e.is_halt = hlt;
    e.rf = r;
    e.c1 = c1;
    e.c2 = c2;
    e.lat = hlt ? 3 + iw : 3 + iw + ((mr | mw) ? 1 + lw : 0);
    exp_q.push_back(e);
    dec_r_wen = r; dec_csr_wen1 = c1; dec_csr_wen2 = c2;
    dec_mem_ren = mr; dec_mem_wen = mw; dec_halt = hlt;
    cyc = 0; if_seen = 0; ls_seen = 0; done = 1'b0;
    while (!done && cyc < 50) begin
      @(negedge clock);
      ifu_ack = (if_seen == iw);
      lsu_ack = (ls_seen == lw);
      #1;
      cyc++;
      chk("we_outside_wb", (pc_wen | rf_wen | csr_wen1 | csr_wen2) & ~retire, 1'b0);
      if (ifu_req) if_seen++;
      if (lsu_req) ls_seen++;
      if (retire || halted) begin
        e = exp_q.pop_front();
        chk("end_kind", halted, e.is_halt);
        chk("latency", cyc, e.lat);
        if (!e.is_halt) begin
          chk("wb_enables", {pc_wen, rf_wen, csr_wen1, csr_wen2}, {1'b1, e.rf, e.c1, e.c2});
        end else begin
          chk("halt_no_retire", {retire, pc_wen, rf_wen, bus_err}, 4'b0000);
        end
        done = 1'b1;
      end
    end
    chk("instr_done", done, 1'b1);
    if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    ifu_ack = 1'b0;
    lsu_ack = 1'b0;
  endtask

  initial begin
    int req_cnt;
    bit early_err;
`ifdef YSYX_25010008_PERF_EN
    logic [31:0] stall0;
    logic [63:0] cyc0;
`endif
    ifu_ack = 1'b0; lsu_ack = 1'b0;
    dec_r_wen = 1'b0; dec_csr_wen1 = 1'b0; dec_csr_wen2 = 1'b0;
    dec_mem_ren = 1'b0; dec_mem_wen = 1'b0; dec_halt = 1'b0;
    do_reset(2);

    for (int i = 0; i < 3; i++) run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef YSYX_25010008_PERF_EN
    stall0 = perf_mem_stall;
`endif
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
`ifdef YSYX_25010008_PERF_EN
    chk("perf_mem_stall", perf_mem_stall - stall0, 32'd2);
`endif
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
    run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TO, 0);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, TO);
    chk("no_bus_err_at_limit", {bus_err, halted}, 2'b00);

    do_reset(1);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
`ifdef YSYX_25010008_PERF_EN
    chk("perf_retire_halt", perf_retire, 64'd2);
    cyc0 = perf_cycle;
`endif
    ifu_ack = 1'b1;
    lsu_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1 chk("halt_hold", {ifu_req, lsu_req, retire, pc_wen, inst_wen, halted}, 6'b000001);
    end
`ifdef YSYX_25010008_PERF_EN
    chk("perf_retire_frozen", perf_retire, 64'd2);
    chk("perf_cycle_frozen", perf_cycle, cyc0);
`endif

    do_reset(1);
    ifu_ack = 1'b0;
    req_cnt = 0;
    early_err = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) begin
      @(negedge clock);
      #1;
      if (ifu_req) req_cnt++;
      if (bus_err && !halted) early_err = 1'b1;
    end
    chk("timeout_req_cycles", req_cnt, TO + 1);
    chk("timeout_halt", {halted, bus_err, ifu_req}, 3'b110);
    chk("bus_err_early", early_err, 1'b0);

    do_reset(1);
    @(negedge clock);
    #1 chk("req_after_reset", outs, 10'b1000000000);
    ifu_ack = 1'b1;
    dec_r_wen = 1'b1; dec_csr_wen1 = 1'b1; dec_csr_wen2 = 1'b0;
    dec_mem_ren = 1'b0; dec_mem_wen = 1'b0; dec_halt = 1'b0;
    @(negedge clock);
    ifu_ack = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1 chk("we_in_reset", {pc_wen, rf_wen, csr_wen1, retire}, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    ifu_ack = 1'b1;
    #1 chk("idle_after_midop", outs, 10'd0);
    ifu_ack = 1'b0;
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
